disp_reader: RTL
================

# disp_reader

Read-out engine for the 1024x1 decoded-bit display memory. On a start pulse it reads a run of bits from that memory, packs them into bytes and hands them downstream over a valid/ready handshake. It is the consumer at the far end of the traceback writer. It shares the memory's single port, and the memory performs a read only in cycles where the writer holds write enable low.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DEPTH, 1024, memory depth in bits; address arithmetic is modulo DEPTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first bit address, sampled with start
- len  in  ADDR_W+1  number of bits to read, sampled with start
- busy  out  1  high from the start-sampling edge until done
- done  out  1  one-cycle pulse when the run completes
- mem_wr  in  1  writer's write enable, observed only; when high, no read occurs this cycle
- mem_addr  out  ADDR_W  read address; the external mux selects it when mem_wr is low
- mem_d  in  1  memory read data, valid the cycle after a read is issued
- out_data  out  8  packed byte
- out_valid  out  1  byte available
- out_ready  in  1  downstream accepts byte
- out_last  out  1  qualifies the final byte of the run

## Operation
- States:
  - IDLE: start=1 with len≠0 → FETCH; start=1 with len=0 → DONE.
  - FETCH: reads are issued until len bits have been issued → DRAIN.
  - DRAIN: waits for the final byte handshake → DONE.
  - DONE: pulses done for one cycle → IDLE.
- Length handling:
  - len>DEPTH saturates to DEPTH.
  - len=0 produces no bytes; done pulses one cycle after the start edge.
- Read issue:
  - A read is issued in a FETCH cycle when mem_wr=0 and packing space allows.
  - An issued read sets the in-flight flag; mem_addr increments at the next edge.
  - mem_addr wraps from DEPTH-1 to 0.
  - When mem_wr=1, nothing is issued, mem_addr holds, and the read retries next cycle.
- Bit capture:
  - A bit with the in-flight flag set is captured from mem_d at the next edge into an 8-bit shift register.
  - First bit read lands in out_data[7] (MSB first).
- Byte transfer:
  - Once 8 bits are captured, or the final bit of the run is captured, the shift register moves to the holding register and out_valid is set.
  - A partial final byte is zero-padded in the unused low bits; out_last=1 with it.
- Handshake:
  - A transfer occurs on an edge where out_valid and out_ready are both high.
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - A new byte may load on the same edge the held byte is accepted, so there is no bubble.
- Backpressure:
  - No read is issued if captured bits plus in-flight bits equal 8 while the holding register is full and out_ready=0.
  - The shift register never overflows and no bit is dropped.
- Start handling: start while busy is ignored.
- Asynchronous reset: all state is cleared, including mid-run. In-flight reads are discarded; the next start begins a fresh run.
- Reset values: busy=0, done=0, mem_addr=0, out_data=0, out_valid=0, out_last=0; FSM in IDLE.

## Timing
- Start is sampled at edge E0; mem_addr=base_addr during the cycle after E0.
- Memory samples at E1; bit 0 is captured at E2.
- With no stalls, one bit per cycle: byte 0 gives out_valid=1 after E9.
- Each cycle with mem_wr=1 during FETCH delays the subsequent bytes by one cycle.
- done pulses the cycle after the edge that accepts the out_last byte; busy falls with done.
- Throughput: one byte per 8 cycles, sustained under out_ready=1 and mem_wr=0.

## Configuration
- DISP_LSB_FIRST_EN defined: the first bit of each byte lands in out_data[0]. A partial final byte is zero-padded in the high bits.
- DISP_LSB_FIRST_EN undefined: MSB-first packing as above.
- Handshake and timing are identical in both builds.

## Structure
- Shared package disp_pkg holds:
  - DISP_ADDR_W=10 and DISP_DEPTH=1024;
  - the state enum (IDLE, FETCH, DRAIN, DONE).
- Sub-module disp_packer holds the shift register, bit counter, holding register and the out_* handshake. Its bit input is mem_d qualified by the in-flight flag, plus a last flag.
- The top level holds the FSM, length saturation, address counter and issue/stall logic.

## Test plan
- Memory preloaded with 0xA5 at bits 0..7; base=0, len=8, out_ready=1 → one byte 0xA5 with out_last=1, out_valid after E9, done one cycle after acceptance.
- base=1020, len=8 with bits 1020..1023,0..3 = 1,1,0,0,1,0,1,0 → byte 0xCA; confirms address wrap.
- len=11 with bits 1,1,1,1,1,1,1,1,1,0,1 → bytes 0xFF then 0xA0 with out_last=1; LSB build gives 0xFF then 0x05.
- mem_wr=1 for 3 cycles mid-byte → same byte values, out_valid delayed exactly 3 cycles, mem_addr frozen while mem_wr=1.
- out_ready=0 for 20 cycles during len=24 → at most 8 pending bits, no loss, bytes delivered in order once ready rises.
- len=0 → done one cycle after start with no bytes. Reset during FETCH → outputs at reset values; a following run produces correct data.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and FSM state type for the display-memory read-out engine.
package disp_pkg;

    localparam int unsigned DISP_ADDR_W = 10;
    localparam int unsigned DISP_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/disp_if.sv
// Memory read port and byte-stream handshake between disp_reader and its neighbours.
interface disp_if
    import disp_pkg::*;
#(
    parameter int unsigned ADDR_W = DISP_ADDR_W
) ();

    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_d;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  mem_wr, mem_d, out_ready,
        output mem_addr, out_data, out_valid, out_last
    );

    modport slave (
        output mem_wr, mem_d, out_ready,
        input  mem_addr, out_data, out_valid, out_last
    );

endinterface

// File: rtl/disp_packer.sv
// Bit-to-byte packer with holding register and valid/ready output.
// DISP_LSB_FIRST_EN selects LSB-first packing; default is MSB-first.
module disp_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_v,
    input  logic       bit_d,
    input  logic       bit_last,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       stall_c
);

    localparam int unsigned CNT_W = 4;

    logic [7:0]       sh_q, sh_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             cmp_q, cmp_n;
    logic             lst_q, lst_n;
    logic [2:0]       pos;
    logic             hold_free_c;

    assign hold_free_c = !out_valid || out_ready;
    // Captured plus in-flight bits already fill a byte and the holding register cannot drain.
    assign stall_c     = ((cnt_q + {3'b000, bit_v}) == CNT_W'(8)) && !hold_free_c;

    // Bits are written by position into a cleared register, so a short final byte is zero-padded.
    always_comb begin
        sh_n  = sh_q;
        cnt_n = cnt_q;
        cmp_n = cmp_q;
        lst_n = lst_q;
        pos   = cnt_q[2:0];
        if (bit_v) begin
`ifdef DISP_LSB_FIRST_EN
            sh_n[pos] = bit_d;
`else
            sh_n[3'd7 - pos] = bit_d;
`endif
            cnt_n = cnt_q + CNT_W'(1);
            lst_n = bit_last;
            cmp_n = (cnt_n == CNT_W'(8)) || bit_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            cnt_q     <= '0;
            cmp_q     <= 1'b0;
            lst_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (cmp_n && hold_free_c) begin
            out_data  <= sh_n;
            out_valid <= 1'b1;
            out_last  <= lst_n;
            sh_q      <= '0;
            cnt_q     <= '0;
            cmp_q     <= 1'b0;
            lst_q     <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            sh_q  <= sh_n;
            cnt_q <= cnt_n;
            cmp_q <= cmp_n;
            lst_q <= lst_n;
        end
    end

endmodule

// File: rtl/disp_reader.sv
// Read-out engine: fetches a run of bits from the 1024x1 display memory and streams bytes.
// Packing order is set in disp_packer by DISP_LSB_FIRST_EN.
module disp_reader
    import disp_pkg::*;
#(
    parameter int unsigned ADDR_W = DISP_ADDR_W,
    parameter int unsigned DEPTH  = DISP_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    disp_if.master            bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    disp_state_e       state_q, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  sat_len_c;
    logic              inflight_q, inflight_last_q;
    logic              issue_c, stall_c, final_acc_c;
    logic              busy_n, done_n;

    assign sat_len_c   = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    assign issue_c     = (state_q == FETCH) && !bus.mem_wr && !stall_c;
    assign final_acc_c = bus.out_valid && bus.out_ready && bus.out_last;
    assign bus.mem_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (start) state_n = (len == '0) ? DONE : FETCH;
            FETCH:   if (issue_c && (rem_q == LEN_W'(1))) state_n = DRAIN;
            DRAIN:   if (final_acc_c) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_n;
            done <= done_n;
        end
    end

    // Address counter, remaining-issue count and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                addr_q <= base_addr;
                rem_q  <= sat_len_c;
            end else if (issue_c) begin
                addr_q <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                rem_q  <= rem_q - LEN_W'(1);
            end
            inflight_q      <= issue_c;
            inflight_last_q <= issue_c && (rem_q == LEN_W'(1));
        end
    end

    disp_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_v     (inflight_q),
        .bit_d     (bus.mem_d & inflight_q),
        .bit_last  (inflight_last_q),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last),
        .stall_c   (stall_c)
    );

endmodule
